// File: rtl/ntt_pkg.sv
// Shared types, counter-width helpers and elaboration-time constant functions
// for the iterative NTT core (twiddle ROM contents, D^-1, bit reversal).
package ntt_pkg;

    typedef enum logic [1:0] {
        s_load    = 2'd0,
        s_compute = 2'd1,
        s_unload  = 2'd2
    } state_t;

    function automatic int cnt_w(int d);
        return $clog2(d);
    endfunction

    function automatic int stage_w(int d);
        int w;
        w = $clog2($clog2(d));
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned bitrev(int unsigned x, int bits);
        int unsigned r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            r = (r << 1) | ((x >> i) & 32'd1);
        end
        return r;
    endfunction

    function automatic longint unsigned modpow(longint unsigned b,
                                               longint unsigned e,
                                               longint unsigned q);
        longint unsigned r;
        longint unsigned x;
        longint unsigned k;
        r = 1;
        x = b % q;
        k = e;
        while (k != 0) begin
            if (k[0]) r = (r * x) % q;
            x = (x * x) % q;
            k = k >> 1;
        end
        return r;
    endfunction

    // w^j for the forward transform, (w^-1)^j for the inverse
    function automatic longint unsigned twiddle(longint unsigned j,
                                                bit              inverse,
                                                longint unsigned d,
                                                longint unsigned q,
                                                longint unsigned g);
        longint unsigned w;
        w = modpow(g, (q - 1) / d, q);
        if (inverse) w = modpow(w, q - 2, q);
        return modpow(w, j, q);
    endfunction

    function automatic longint unsigned inv_d(longint unsigned d, longint unsigned q);
        return modpow(d, q - 2, q);
    endfunction

    function automatic bit params_ok(int n, longint unsigned d,
                                     longint unsigned q, longint unsigned g);
        longint unsigned two_n;
        longint unsigned w;
        if (d < 4 || d > 1024 || (d & (d - 1)) != 0) return 1'b0;
        if (n < 2 || n > 32) return 1'b0;
        two_n = 64'd1 << n;
        if (q >= two_n || two_n > 2 * q) return 1'b0;
        if ((q - 1) % d != 0) return 1'b0;
        // w must have order exactly D: w^(D/2) == -1
        w = modpow(g, (q - 1) / d, q);
        if (modpow(w, d / 2, q) != q - 1) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/ntt_iter_core_mod_mult.sv
// Combinational modular multiplier: p = a*b mod Q with a full 2N-bit product.
module mod_mult #(
    parameter int          N = 17,
    parameter int unsigned Q = 65537
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] p
);

    logic [2*N-1:0] prod;

    assign prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    assign p    = N'(prod % (2*N)'(Q));

endmodule

// File: rtl/ntt_iter_core.sv
// Iterative radix-2 DIT NTT: bit-reversed load, one butterfly per clock in
// place, natural-order unload with D^-1 scaling for the inverse transform.
//
// state     | meaning
// s_load    | accept D beats into bit-reversed slots of the coefficient array
// s_compute | log2(D) stages of D/2 butterflies, one per clock
// s_unload  | stream array in index order, scaled by D^-1 when inverse
module ntt_iter_core
    import ntt_pkg::*;
#(
    parameter int          N = 17,
    parameter int          D = 16,
    parameter int unsigned Q = 65537,
    parameter int unsigned G = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy
);

    localparam int             lw     = cnt_w(D);
    localparam int             sw     = stage_w(D);
    localparam int             nstg   = $clog2(D);
    localparam logic [N:0]     q_w    = (N+1)'(Q);
    localparam logic [N-1:0]   inv_dn = N'(inv_d(64'(D), 64'(Q)));

    if (!params_ok(N, 64'(D), 64'(Q), 64'(G))) begin : g_param_err
        $error("ntt_iter_core: illegal N/D/Q/G combination");
    end

    state_t          state;
    state_t          state_nx;
    logic [N-1:0]    coef [D];
    logic [lw-1:0]   ld_cnt;
    logic [lw-1:0]   ul_idx;
    logic [lw-1:0]   ld_addr;
    logic [lw-2:0]   bfy;
    logic [sw-1:0]   stg;
    logic            mode_inv;
    logic            ld_fire;
    logic            ul_fire;
    logic            bfy_last;
    logic            stg_last;

    logic [lw-1:0]   bfy_ext;
    logic [lw-1:0]   lo_mask;
    logic [lw-1:0]   idx_u;
    logic [lw-1:0]   idx_t;
    logic [lw-2:0]   tw_exp;

    logic [N-1:0]    in_red;
    logic [N-1:0]    u;
    logic [N-1:0]    t;
    logic [N-1:0]    tw;
    logic [N-1:0]    mul_a;
    logic [N-1:0]    mul_b;
    logic [N-1:0]    mul_p;
    logic [N-1:0]    bf_sum;
    logic [N-1:0]    bf_dif;
    logic [N:0]      add_raw;

    logic [N-1:0]    tw_fwd [D/2];
    logic [N-1:0]    tw_inv [D/2];

    for (genvar j = 0; j < D/2; j++) begin : g_tw
        assign tw_fwd[j] = N'(twiddle(64'(j), 1'b0, 64'(D), 64'(Q), 64'(G)));
        assign tw_inv[j] = N'(twiddle(64'(j), 1'b1, 64'(D), 64'(Q), 64'(G)));
    end

    assign ld_fire  = in_valid && (state == s_load);
    assign ul_fire  = out_ready && (state == s_unload);
    assign bfy_last = (bfy == (lw-1)'(D/2 - 1));
    assign stg_last = (stg == sw'(nstg - 1));
    assign ld_addr  = lw'(bitrev(32'(ld_cnt), lw));

    // butterfly b of stage s: group = b>>s, pos = b & (2^s-1),
    // i = group*2^(s+1) + pos, partner i + 2^s, twiddle w^(pos * D/2^(s+1))
    always_comb begin
        bfy_ext = {1'b0, bfy};
        lo_mask = (lw'(1) << stg) - lw'(1);
        idx_u   = ((bfy_ext & ~lo_mask) << 1) | (bfy_ext & lo_mask);
        idx_t   = idx_u | (lw'(1) << stg);
        tw_exp  = (bfy & lo_mask[lw-2:0]) << (sw'(nstg - 1) - stg);
    end

    assign u  = coef[idx_u];
    assign t  = coef[idx_t];
    assign tw = mode_inv ? tw_inv[tw_exp] : tw_fwd[tw_exp];

    // the one multiplier serves the butterfly in COMPUTE and D^-1 scaling in UNLOAD
    assign mul_a = (state == s_unload) ? coef[ul_idx] : t;
    assign mul_b = (state == s_unload) ? inv_dn : tw;

    mod_mult #(
        .N (N),
        .Q (Q)
    ) u_mod_mult (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    assign add_raw = {1'b0, u} + {1'b0, mul_p};
    assign bf_sum  = (add_raw >= q_w) ? N'(add_raw - q_w) : N'(add_raw);
    assign bf_dif  = (u >= mul_p) ? (u - mul_p) : N'({1'b0, u} + q_w - {1'b0, mul_p});
    assign in_red  = ({1'b0, in_data} >= q_w) ? N'({1'b0, in_data} - q_w) : in_data;

    assign out_data = mode_inv ? mul_p : coef[ul_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= s_load;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            s_load: begin
                in_ready = 1'b1;
                if (ld_fire && ld_cnt == lw'(D - 1)) state_nx = s_compute;
            end
            s_compute: begin
                busy = 1'b1;
                if (bfy_last && stg_last) state_nx = s_unload;
            end
            s_unload: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (ul_fire && ul_idx == lw'(D - 1)) state_nx = s_load;
            end
            default: state_nx = s_load;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt   <= '0;
            ul_idx   <= '0;
            stg      <= '0;
            bfy      <= '0;
            mode_inv <= 1'b0;
        end else begin
            if (ld_fire) begin
                if (ld_cnt == '0) mode_inv <= mode;
                ld_cnt <= ld_cnt + 1'b1;
            end
            if (state == s_compute) begin
                if (bfy_last) begin
                    bfy <= '0;
                    stg <= stg_last ? '0 : stg + 1'b1;
                end else begin
                    bfy <= bfy + 1'b1;
                end
            end
            if (ul_fire) ul_idx <= ul_idx + 1'b1;
        end
    end

    // coefficient storage carries no reset; a new block always overwrites it
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            coef[ld_addr] <= in_red;
        end else if (state == s_compute) begin
            coef[idx_u] <= bf_sum;
            coef[idx_t] <= bf_dif;
        end
    end

endmodule

// File: doc/ntt_iter_core.md
NTT_ITER_CORE -- requirements
Module: ntt_iter_core

Interface
REQ-001 SHALL provide parameter N, default 17, coefficient width in bits.
REQ-002 SHALL provide parameter D, default 16, transform length; power of two, 4..1024.
REQ-003 SHALL provide parameter Q, default 65537, prime modulus; D divides Q-1; Q < 2^N <= 2Q, else elaboration error.
REQ-004 SHALL provide parameter G, default 3, primitive root mod Q; w = G^((Q-1)/D) mod Q.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  in_data beat valid.
REQ-008 in_ready  output  1  core accepts a load beat.
REQ-009 in_data  input  N  coefficient, index order 0..D-1.
REQ-010 mode  input  1  0 = forward NTT, 1 = inverse NTT; sampled on the first accepted beat of a block.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  downstream accepts output beat.
REQ-013 out_data  output  N  result coefficient, index order 0..D-1, always < Q.
REQ-014 busy  output  1  high in COMPUTE and UNLOAD.

Function
REQ-015 SHALL compute the cyclic transform X[k] = sum_n a[n]*w^(nk) mod Q (forward) or a[n] = D^-1 * sum_k X[k]*w^(-nk) mod Q (inverse).
REQ-016 SHALL implement states LOAD -> COMPUTE -> UNLOAD -> LOAD, one butterfly per clock, operating on a D-entry N-bit coefficient register array.
REQ-017 LOAD: in_ready=1; each in_valid&&in_ready beat writes to address bitrev(count), count increments; after beat D-1, go to COMPUTE next cycle.
REQ-018 Beats with in_data >= Q SHALL be reduced by one conditional subtraction of Q on write.
REQ-019 COMPUTE: log2(D) stages of D/2 Cooley-Tukey DIT butterflies (u+t*w^j, u-t*w^j mod Q); exactly (D/2)*log2(D) cycles (32 at defaults); inverse uses w^-1 twiddles.
REQ-020 UNLOAD: out_valid=1; out_data = array[idx] (forward) or array[idx]*D^-1 mod Q (inverse; 61441 at defaults); idx advances only on out_valid&&out_ready.
REQ-021 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 After the handshake of beat D-1, SHALL return to LOAD with in_ready=1 on the next cycle.
REQ-023 in_ready SHALL be 0 outside LOAD; in_valid there is ignored.
REQ-024 out_valid SHALL be 0 outside UNLOAD.
REQ-025 in_valid deasserted mid-load SHALL stall LOAD indefinitely without corrupting loaded data.
REQ-026 All modular add/sub SHALL use single conditional correction; products SHALL be fully reduced mod Q (2N-bit intermediate).

Reset
REQ-027 rst_n low SHALL immediately force state LOAD, load/stage/butterfly/unload counters 0, in_ready=1 (after release), out_valid=0, busy=0, latched mode=0.
REQ-028 Reset in any state SHALL discard partial data; the coefficient array need not be cleared.
REQ-029 First beat accepted after rst_n rises SHALL be index 0 of a new block.

Structure
REQ-030 Package ntt_pkg SHALL hold: state enum, clog2-based counter widths, constant functions bitrev(), modpow(), twiddle(j, inverse), inv_d(); twiddles are elaboration-time constants (ROM).
REQ-031 SHALL instantiate one sub-module mod_mult (N-bit a*b mod Q, combinational), shared by butterfly and D^-1 scaling.

Verification
REQ-032 Forward, input [1,0,...,0] -> output 16 ones.
REQ-033 Forward, input 16 ones -> [16,0,...,0]; inverse, input 16 ones -> [1,0,...,0].
REQ-034 Forward of ramp 0..15, then inverse of that output -> 0..15 exactly; compute phase measured at 32 cycles, each time.
REQ-035 Input beat 65537 at index 0, rest 0, forward -> all zeros.
REQ-036 out_ready toggled pseudo-randomly during UNLOAD -> 16 beats, no drop or duplicate, data stable while stalled.
REQ-037 rst_n pulsed low at COMPUTE cycle 10 -> out_valid stays 0, in_ready=1 one cycle after release, next block (impulse) yields 16 ones.
